// File: rtl/gate_response_checker.sv
// gate_response_checker: on start, drives {a,b} = 00,01,10,11 onto a 2-input
// gate under test, holding each vector HOLD_CYCLES clocks. The gate output is
// sampled on the last clock of each vector and compared with TRUTH[{a,b}].
// Per-vector failures, a saturating error count and a pass flag are reported.
module gate_response_checker #(
  parameter int         HOLD_CYCLES = 2,
  parameter logic [3:0] TRUTH       = 4'b0111,
  parameter int         ERR_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_out,
  output logic             stim_a,
  output logic             stim_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  // A single-clock hold still needs a one-bit counter so the compare is legal.
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [HC_W-1:0]  hc_q, hc_d;
  logic [1:0]       stim_q, stim_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       fv_q, fv_d;
  logic             pass_q, pass_d;

  // State and result registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      hc_q    <= '0;
      stim_q  <= 2'b00;
      err_q   <= '0;
      fv_q    <= 4'b0000;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hc_q    <= hc_d;
      stim_q  <= stim_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic: vector sequencing, response compare and result update.
  // The stimulus register is loaded one edge ahead so {a,b} equals idx during RUN.
  // pass is loaded on the final compare edge so it is valid alongside done.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hc_d    = hc_q;
    stim_d  = stim_q;
    err_d   = err_q;
    fv_d    = fv_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = 2'd0;
          hc_d    = '0;
          stim_d  = 2'b00;
          err_d   = '0;
          fv_d    = 4'b0000;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        hc_d = hc_q + HC_W'(1);
        if (hc_q == HC_LAST) begin
          hc_d = '0;
          if (dut_out != TRUTH[idx_q]) begin
            fv_d[idx_q] = 1'b1;
            if (err_q != {ERR_W{1'b1}}) begin
              err_d = err_q + ERR_W'(1);
            end
          end
          if (idx_q == 2'd3) begin
            state_d = DONE;
            stim_d  = 2'b00;
            pass_d  = (fv_d == 4'b0000);
          end else begin
            idx_d  = idx_q + 2'd1;
            stim_d = idx_q + 2'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stim_a    = stim_q[1];
  assign stim_b    = stim_q[0];
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fv_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker (H=2, NAND truth table). A second instance
// with ERR_W=1 shares all inputs to check error-count saturation.
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dut_out;
  logic       stim_a, stim_b, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic       stim_a1, stim_b1, busy1, done1, pass1;
  logic [0:0] err_count1;
  logic [3:0] fail_vec1;

  // 0 = ideal NAND, 1 = stuck at 1, 2 = stuck at 0
  int mode;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      1:       dut_out = 1'b1;
      2:       dut_out = 1'b0;
      default: dut_out = ~(stim_a & stim_b);
    endcase
  end

  gate_response_checker #(.HOLD_CYCLES(2), .TRUTH(4'b0111), .ERR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out),
    .stim_a(stim_a), .stim_b(stim_b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  gate_response_checker #(.HOLD_CYCLES(2), .TRUTH(4'b0111), .ERR_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out),
    .stim_a(stim_a1), .stim_b(stim_b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err_count1), .fail_vec(fail_vec1)
  );

  typedef struct {
    int         mode;
    logic       exp_pass;
    logic [2:0] exp_err;
    logic [3:0] exp_fv;
    logic [0:0] exp_err1;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Runs one start pulse and checks cycles 1..9 of the run. With extra_start,
  // start is also driven high in cycles 3 and 9 and must be ignored.
  task automatic run_check(input bit extra_start, input logic exp_pass,
                           input logic [2:0] exp_err, input logic [3:0] exp_fv);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("stim_c%0d", c), {30'd0, stim_a, stim_b}, 32'((c - 1) / 2));
      chk($sformatf("busy_c%0d", c), {31'd0, busy}, 32'd1);
      chk($sformatf("done_c%0d", c), {31'd0, done}, 32'd0);
      start = (extra_start && c == 3);
      @(negedge clk);
      start = (extra_start && c == 8);
    end
    chk("done_c9", {31'd0, done}, 32'd1);
    chk("busy_c9", {31'd0, busy}, 32'd0);
    chk("stim_c9", {30'd0, stim_a, stim_b}, 32'd0);
    chk("pass_c9", {31'd0, pass}, {31'd0, exp_pass});
    chk("err_c9", {29'd0, err_count}, {29'd0, exp_err});
    chk("fv_c9", {28'd0, fail_vec}, {28'd0, exp_fv});
    @(negedge clk); start = 1'b0;
    chk("done_c10", {31'd0, done}, 32'd0);
    chk("busy_c10", {31'd0, busy}, 32'd0);
    chk("pass_hold_c10", {31'd0, pass}, {31'd0, exp_pass});
    @(negedge clk);
    chk("busy_c11", {31'd0, busy}, 32'd0);
    chk("fv_hold_c11", {28'd0, fail_vec}, {28'd0, exp_fv});
  endtask

  initial begin
    vecs[0] = '{0, 1'b1, 3'd0, 4'b0000, 1'b0};
    vecs[1] = '{1, 1'b0, 3'd1, 4'b1000, 1'b1};
    vecs[2] = '{2, 1'b0, 3'd3, 4'b0111, 1'b1};
    vecs[3] = '{0, 1'b1, 3'd0, 4'b0000, 1'b0};

    mode  = 0;
    start = 1'b0;
    rst   = 1'b1;
    #2;
    chk("rst_stim", {30'd0, stim_a, stim_b}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_err", {29'd0, err_count}, 32'd0);
    chk("rst_fv", {28'd0, fail_vec}, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      mode = vecs[i].mode;
      run_check(1'b0, vecs[i].exp_pass, vecs[i].exp_err, vecs[i].exp_fv);
      chk($sformatf("err1_v%0d", i), {31'd0, err_count1}, {31'd0, vecs[i].exp_err1});
      chk($sformatf("fv1_v%0d", i), {28'd0, fail_vec1}, {28'd0, vecs[i].exp_fv});
    end

    // Extra start pulses during RUN and DONE are ignored.
    mode = 0;
    run_check(1'b1, 1'b1, 3'd0, 4'b0000);

    // Stuck-at-0 run leaves errors, then reset in cycle 5 of a new run.
    mode = 2;
    run_check(1'b0, 1'b0, 3'd3, 4'b0111);
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pre_stim", {30'd0, stim_a, stim_b}, 32'd2);
    chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_stim", {30'd0, stim_a, stim_b}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_pass", {31'd0, pass}, 32'd0);
    chk("arst_err", {29'd0, err_count}, 32'd0);
    chk("arst_fv", {28'd0, fail_vec}, 32'd0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("post_rst_done%0d", c), {31'd0, done}, 32'd0);
      chk($sformatf("post_rst_busy%0d", c), {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
    run_check(1'b0, 1'b1, 3'd0, 4'b0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
